spi_reg_sequencer: RTL and testbench
====================================

SPI_REG_SEQUENCER -- requirements
Module: spi_reg_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 32, number of valid register addresses (0..NUM_REGS-1); SHALL be in the range 1..64.
REQ-002 sclk  input  1  SPI serial clock; all sequential logic SHALL run on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cs_n  input  1  chip select, active-low; high = no frame in progress.
REQ-005 rx_valid  input  1  one-cycle pulse: a complete received byte is present on rx_byte.
REQ-006 rx_byte  input  8  received byte; valid only while rx_valid=1.
REQ-007 reg_rdata  input  8  read data from the register file; combinationally valid for the current reg_addr.
REQ-008 reg_addr  output  6  register address.
REQ-009 reg_wdata  output  8  register write data.
REQ-010 reg_we  output  1  one-cycle write strobe.
REQ-011 reg_re  output  1  one-cycle read strobe.
REQ-012 tx_byte  output  8  next byte to shift out on MISO.
REQ-013 tx_valid  output  1  one-cycle pulse: tx_byte has been updated.
REQ-014 err  output  1  sticky flag: an out-of-range access occurred in the current frame.
REQ-015 byte_cnt  output  8  number of bytes received in the current frame; saturates at 255.

Function
REQ-016 The FSM SHALL have exactly three states: CMD (await command byte), WR (write data phase) and RD (read data phase).
REQ-017 Command byte format SHALL be: bit7 = 1 for write / 0 for read; bit6 = burst (auto-increment); bits5:0 = start address.
REQ-018 In CMD, rx_valid=1 SHALL latch the address and burst bit, clear err, and move to WR (bit7=1) or RD (bit7=0) on the same edge.
REQ-019 Write phase: rx_valid with byte D at cycle N SHALL produce reg_we=1, reg_wdata=D, reg_addr=current address during cycle N+1 only.
REQ-020 A write to an address >= NUM_REGS SHALL keep reg_we=0 and SHALL set err=1 from cycle N+1.
REQ-021 Read entry: the edge that accepts a read command (cycle N) SHALL produce reg_re=1 for cycle N+1 at the start address.
REQ-022 At the end of cycle N+1, tx_byte SHALL register reg_rdata, or 0x00 plus err=1 if the address is >= NUM_REGS.
REQ-023 tx_valid SHALL pulse during cycle N+2.
REQ-024 In RD, each further rx_valid byte SHALL be treated as a dummy: its content is ignored and it triggers the next read with the timing of REQ-021 to REQ-023.
REQ-025 Burst=1: the address SHALL increment by 1 after each completed access, visible from the cycle after the strobe cycle.
REQ-026 Burst=1: the address SHALL wrap from 63 to 0.
REQ-027 Burst=0: the address SHALL stay fixed; repeated writes overwrite the same register and repeated reads re-read it.
REQ-028 Read prefetch: the first read SHALL be issued at command acceptance, so the byte following the command returns data for the start address.
REQ-029 Read prefetch: the next read SHALL be issued on each dummy byte.
REQ-030 reg_we and reg_re SHALL never be high in the same cycle.
REQ-031 Each strobe SHALL be high for exactly one cycle per accepted byte.
REQ-032 byte_cnt SHALL increment on every rx_valid while cs_n=0 and saturate at 255.
REQ-033 cs_n high SHALL asynchronously force state to CMD, byte_cnt to 0, and reg_we/reg_re/tx_valid to 0.
REQ-034 cs_n high SHALL leave tx_byte, reg_addr, reg_wdata and err unchanged.
REQ-035 rx_valid while cs_n=1 SHALL be ignored.
REQ-036 cs_n rising in the same cycle as a pending strobe SHALL cancel that strobe: no write or read occurs.

Reset
REQ-037 rst_n low SHALL asynchronously set state=CMD, reg_addr=0, reg_wdata=0x00, reg_we=0, reg_re=0, tx_byte=0x00, tx_valid=0, err=0, byte_cnt=0.
REQ-038 rst_n low mid-frame SHALL abort any pending strobe.
REQ-039 After rst_n deasserts, the first rx_valid SHALL be decoded as a command byte.

Verification
REQ-040 Single write: cmd 0x85, data 0xA5 -> one reg_we pulse with addr 0x05 and wdata 0xA5; byte_cnt=2.
REQ-041 Burst write: cmd 0xDE, data 0x11,0x22,0x33 -> writes to addr 0x1E, 0x1F, 0x20; third write suppressed, err=1 (NUM_REGS=32).
REQ-042 Burst read with wrap: NUM_REGS=64, cmd 0x7F, 2 dummy bytes -> reg_re at addr 0x3F, 0x00, 0x01; tx_byte tracks reg_rdata each time, tx_valid pulses 3 times.
REQ-043 Non-burst read: cmd 0x03, 3 dummy bytes -> 4 reg_re pulses, all at addr 0x03.
REQ-044 Abort: cs_n rises one cycle after a write data byte's rx_valid -> no reg_we; the next frame's first byte is decoded as a command.
REQ-045 Reset mid-burst: rst_n low during the WR phase -> all outputs at REQ-037 values; the next byte is treated as a command.

Source files
------------

// File: rtl/spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// spi_reg_sequencer
//
// Turns a stream of received SPI bytes into register-file accesses.
// The first byte of a frame is a command byte: bit7 selects write (1) or
// read (0), bit6 enables address auto-increment, and bits5:0 give the start
// address. Every following byte is either write data or, in a read frame, a
// dummy byte that launches the next read. Reads are prefetched: the first read
// is issued when the command is accepted, so the byte shifted out after the
// command already carries data for the start address.
//
// Ports
//   sclk       in   SPI serial clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   cs_n       in   chip select, active-low; high ends/aborts the frame
//   rx_valid   in   one-cycle pulse, rx_byte holds a complete byte
//   rx_byte    in   received byte
//   reg_rdata  in   register read data for the current reg_addr (combinational)
//   reg_addr   out  register address
//   reg_wdata  out  register write data
//   reg_we     out  one-cycle write strobe
//   reg_re     out  one-cycle read strobe
//   tx_byte    out  next byte to shift out on MISO
//   tx_valid   out  one-cycle pulse, tx_byte was just updated
//   err        out  sticky out-of-range flag, cleared by the next command byte
//   byte_cnt   out  bytes received in the current frame, saturates at 255
//
// State | meaning
// ------+---------------------------------------------------
// CMD   | waiting for the command byte of a frame
// WR    | each received byte is written to the current address
// RD    | each received byte is a dummy that launches the next read
// -----------------------------------------------------------------------------
module spi_reg_sequencer #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [7:0] reg_rdata,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       err,
    output logic [7:0] byte_cnt
);

    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_num_regs_check
        $error("spi_reg_sequencer: NUM_REGS must be in the range 1..64");
    end

    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    typedef enum logic [1:0] {
        S_CMD = 2'd0,
        S_WR  = 2'd1,
        S_RD  = 2'd2
    } state_t;

    state_t     state_q;
    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] tx_q;
    logic [7:0] cnt_q;
    logic       we_q;
    logic       re_q;
    logic       wacc_q;   // write slot in progress, set even when the write is suppressed
    logic       txv_q;
    logic       err_q;
    logic       burst_q;

    logic       rx_ok;
    logic [5:0] addr_eff;

    function automatic logic in_range(input logic [5:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    assign rx_ok = rx_valid & ~cs_n;

    // Address that is current once the access in flight has completed. The
    // post-increment lands on the edge that ends the strobe cycle, so a byte
    // accepted on that same edge must already target the incremented address.
    assign addr_eff = ((wacc_q | re_q) && burst_q) ? addr_q + 6'd1 : addr_q;

    // Frame control: cs_n high clears this group asynchronously so that a
    // strobe still pending when the frame ends never reaches the register file.
    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n || cs_n) begin
            state_q <= S_CMD;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wacc_q  <= 1'b0;
            txv_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            wacc_q <= 1'b0;
            txv_q  <= re_q;
            if (rx_ok) begin
                cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
            case (state_q)
                S_CMD: begin
                    if (rx_ok) begin
                        if (rx_byte[7]) begin
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                            re_q    <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (rx_ok) begin
                        wacc_q <= 1'b1;
                        we_q   <= in_range(addr_eff);
                    end
                end
                S_RD: begin
                    if (rx_ok) begin
                        re_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_CMD;
                end
            endcase
        end
    end

    // Datapath: survives cs_n so the last address, data and error stay visible.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 6'd0;
            wdata_q <= 8'h00;
            tx_q    <= 8'h00;
            err_q   <= 1'b0;
            burst_q <= 1'b0;
        end else begin
            addr_q <= addr_eff;
            if (re_q) begin
                if (in_range(addr_q)) begin
                    tx_q <= reg_rdata;
                end else begin
                    tx_q  <= 8'h00;
                    err_q <= 1'b1;
                end
            end
            if (rx_ok) begin
                case (state_q)
                    S_CMD: begin
                        addr_q  <= rx_byte[5:0];
                        burst_q <= rx_byte[6];
                        err_q   <= 1'b0;
                    end
                    S_WR: begin
                        wdata_q <= rx_byte;
                        if (!in_range(addr_eff)) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign tx_byte   = tx_q;
    assign tx_valid  = txv_q;
    assign err       = err_q;
    assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for spi_reg_sequencer. Two instances share all inputs: one with the
// default NUM_REGS=32 and one with NUM_REGS=64. Each frame's strobes and
// tx updates are logged and compared against hand-written vectors or against
// a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_spi_reg_sequencer;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_byte;

    logic [7:0] rdata0, rdata1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       we0, we1, re0, re1, txv0, txv1, err0, err1;
    logic [7:0] tx0, tx1, cnt0, cnt1;

    logic [7:0] tab [64];

    always #5 sclk = ~sclk;

    assign rdata0 = tab[addr0];
    assign rdata1 = tab[addr1];

    spi_reg_sequencer u_dut32 (
        .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .reg_rdata(rdata0), .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0),
        .tx_byte(tx0), .tx_valid(txv0), .err(err0), .byte_cnt(cnt0)
    );

    spi_reg_sequencer #(.NUM_REGS(64)) u_dut64 (
        .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .reg_rdata(rdata1), .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1),
        .tx_byte(tx1), .tx_valid(txv1), .err(err1), .byte_cnt(cnt1)
    );

    // ---------------- event logs (sampled mid-cycle) ----------------
    int wlog0[$], wlog1[$], rlog0[$], rlog1[$], tlog0[$], tlog1[$];
    int ovl0, ovl1;

    always @(negedge sclk) begin
        if (we0)  wlog0.push_back(int'(addr0) * 256 + int'(wdata0));
        if (re0)  rlog0.push_back(int'(addr0));
        if (txv0) tlog0.push_back(int'(tx0));
        if (we0 && re0) ovl0++;
        if (we1)  wlog1.push_back(int'(addr1) * 256 + int'(wdata1));
        if (re1)  rlog1.push_back(int'(addr1));
        if (txv1) tlog1.push_back(int'(tx1));
        if (we1 && re1) ovl1++;
    end

    // ---------------- checking ----------------
    int npass = 0;
    int nchk  = 0;

    task automatic check(input string name, input int got, input int exp);
        nchk++;
        if (got == exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Frame bytes and expectations shared by the helpers below.
    logic [7:0] fb[$];
    int ew[$], er[$], et[$];
    int e_err, e_cnt;
    int g_err, g_cnt;

    // Frame-level reference: walk the bytes applying the command rules.
    task automatic model(input int nregs);
        int  a;
        bit  burst;
        logic [7:0] c;
        ew.delete(); er.delete(); et.delete();
        e_err = 0;
        c     = fb[0];
        burst = c[6];
        a     = int'(c[5:0]);
        if (c[7]) begin
            for (int i = 1; i < fb.size(); i++) begin
                if (a < nregs) ew.push_back(a * 256 + int'(fb[i]));
                else e_err = 1;
                if (burst) a = (a + 1) % 64;
            end
        end else begin
            for (int i = 0; i < fb.size(); i++) begin
                er.push_back(a);
                if (a < nregs) et.push_back(int'(tab[a]));
                else begin
                    et.push_back(0);
                    e_err = 1;
                end
                if (burst) a = (a + 1) % 64;
            end
        end
        e_cnt = (fb.size() > 255) ? 255 : fb.size();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic clear_logs();
        wlog0.delete(); wlog1.delete(); rlog0.delete(); rlog1.delete();
        tlog0.delete(); tlog1.delete();
        ovl0 = 0; ovl1 = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cyc($urandom_range(1, 3));
        rx_byte  = b;
        rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    // Expectations (e_err) must be set before calling.
    task automatic run_frame(input string tag, input bit sel);
        clear_logs();
        cs_n = 1'b0;
        cyc(2);
        foreach (fb[i]) send_byte(fb[i]);
        cyc(5);
        @(negedge sclk);
        g_err = sel ? int'(err1) : int'(err0);
        g_cnt = sel ? int'(cnt1) : int'(cnt0);
        cyc(1);
        cs_n = 1'b1;
        @(negedge sclk);
        check({tag, " byte_cnt after cs_n"}, sel ? int'(cnt1) : int'(cnt0), 0);
        check({tag, " err held after cs_n"}, sel ? int'(err1) : int'(err0), e_err);
        cyc(2);
    endtask

    task automatic compare_frame(input string tag, input bit sel);
        int gw[$], gr[$], gt[$], ov;
        if (sel) begin gw = wlog1; gr = rlog1; gt = tlog1; ov = ovl1; end
        else     begin gw = wlog0; gr = rlog0; gt = tlog0; ov = ovl0; end
        check({tag, " write count"}, gw.size(), ew.size());
        for (int i = 0; i < gw.size() && i < ew.size(); i++)
            check($sformatf("%s write[%0d] addr/data", tag, i), gw[i], ew[i]);
        check({tag, " read count"}, gr.size(), er.size());
        for (int i = 0; i < gr.size() && i < er.size(); i++)
            check($sformatf("%s read[%0d] addr", tag, i), gr[i], er[i]);
        check({tag, " tx_valid count"}, gt.size(), et.size());
        for (int i = 0; i < gt.size() && i < et.size(); i++)
            check($sformatf("%s tx[%0d]", tag, i), gt[i], et[i]);
        check({tag, " err"}, g_err, e_err);
        check({tag, " byte_cnt"}, g_cnt, e_cnt);
        check({tag, " we/re overlap cycles"}, ov, 0);
    endtask

    task automatic check_reset_vals(input string tag, input bit sel);
        check({tag, " reg_addr"},  sel ? int'(addr1)  : int'(addr0),  0);
        check({tag, " reg_wdata"}, sel ? int'(wdata1) : int'(wdata0), 0);
        check({tag, " reg_we"},    sel ? int'(we1)    : int'(we0),    0);
        check({tag, " reg_re"},    sel ? int'(re1)    : int'(re0),    0);
        check({tag, " tx_byte"},   sel ? int'(tx1)    : int'(tx0),    0);
        check({tag, " tx_valid"},  sel ? int'(txv1)   : int'(txv0),   0);
        check({tag, " err"},       sel ? int'(err1)   : int'(err0),   0);
        check({tag, " byte_cnt"},  sel ? int'(cnt1)   : int'(cnt0),   0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string             name;
        bit                sel;
        int                n;
        logic [5:0][7:0]   b;
        int                nw;
        logic [3:0][15:0]  w;
        int                nr;
        logic [3:0][5:0]   r;
        int                err;
        int                cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (tab[i]) tab[i] = 8'($urandom);
        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;

        vecs[0] = '{name: "single write", sel: 1'b0, n: 2,
                    b: {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h85},
                    nw: 1, w: {16'h0, 16'h0, 16'h0, 16'h05A5},
                    nr: 0, r: '0, err: 0, cnt: 2};
        vecs[1] = '{name: "burst write past end", sel: 1'b0, n: 4,
                    b: {8'h00, 8'h00, 8'h33, 8'h22, 8'h11, 8'hDE},
                    nw: 2, w: {16'h0, 16'h0, 16'h1F22, 16'h1E11},
                    nr: 0, r: '0, err: 1, cnt: 4};
        vecs[2] = '{name: "burst read wrap", sel: 1'b1, n: 3,
                    b: {8'h00, 8'h00, 8'h00, 8'hC3, 8'h5A, 8'h7F},
                    nw: 0, w: '0,
                    nr: 3, r: {6'h00, 6'h01, 6'h00, 6'h3F}, err: 0, cnt: 3};
        vecs[3] = '{name: "fixed read", sel: 1'b0, n: 4,
                    b: {8'h00, 8'h00, 8'h41, 8'h80, 8'hFF, 8'h03},
                    nw: 0, w: '0,
                    nr: 4, r: {6'h03, 6'h03, 6'h03, 6'h03}, err: 0, cnt: 4};
        vecs[4] = '{name: "out of range read", sel: 1'b0, n: 2,
                    b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h25},
                    nw: 0, w: '0,
                    nr: 2, r: {6'h00, 6'h00, 6'h25, 6'h25}, err: 1, cnt: 2};

        // reset values
        cyc(3);
        @(negedge sclk);
        check_reset_vals("reset dut32", 1'b0);
        check_reset_vals("reset dut64", 1'b1);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // directed table
        for (int v = 0; v < 5; v++) begin
            int nregs;
            nregs = vecs[v].sel ? 64 : 32;
            fb.delete();
            for (int i = 0; i < vecs[v].n; i++) fb.push_back(vecs[v].b[i]);
            ew.delete(); er.delete(); et.delete();
            for (int i = 0; i < vecs[v].nw; i++) ew.push_back(int'(vecs[v].w[i]));
            for (int i = 0; i < vecs[v].nr; i++) begin
                int a;
                a = int'(vecs[v].r[i]);
                er.push_back(a);
                et.push_back(a < nregs ? int'(tab[a]) : 0);
            end
            e_err = vecs[v].err;
            e_cnt = vecs[v].cnt;
            run_frame(vecs[v].name, vecs[v].sel);
            compare_frame(vecs[v].name, vecs[v].sel);
        end

        // abort: cs_n rises in the strobe cycle of a write
        clear_logs();
        cs_n = 1'b0;
        cyc(2);
        send_byte(8'h85);
        cyc(2);
        rx_byte = 8'h77; rx_valid = 1'b1;
        cyc(1);
        cs_n = 1'b1; rx_valid = 1'b0;
        cyc(3);
        check("abort no write", wlog0.size(), 0);
        rx_byte = 8'h81; rx_valid = 1'b1;       // ignored while deselected
        cyc(1);
        rx_valid = 1'b0;
        @(negedge sclk);
        check("rx while cs_n high byte_cnt", int'(cnt0), 0);
        cyc(1);
        fb.delete(); fb.push_back(8'h03);
        model(32);
        run_frame("frame after abort", 1'b0);
        compare_frame("frame after abort", 1'b0);

        // reset in the middle of a burst write
        clear_logs();
        cs_n = 1'b0;
        cyc(2);
        send_byte(8'hC4);
        send_byte(8'h10);
        cyc(2);
        rx_byte = 8'h20; rx_valid = 1'b1;
        cyc(1);
        rst_n = 1'b0; rx_valid = 1'b0;
        @(negedge sclk);
        check_reset_vals("mid-burst reset", 1'b0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        send_byte(8'h02);
        cyc(4);
        check("mid-burst write count", wlog0.size(), 1);
        if (wlog0.size() >= 1) check("mid-burst first write", wlog0[0], 16'h0410);
        check("post-reset read count", rlog0.size(), 1);
        if (rlog0.size() >= 1) check("post-reset read addr", rlog0[0], 2);
        check("post-reset tx count", tlog0.size(), 1);
        if (tlog0.size() >= 1) check("post-reset tx byte", tlog0[0], int'(tab[2]));
        cs_n = 1'b1;
        cyc(2);

        // long burst read: byte_cnt saturation and repeated 63->0 wraps
        fb.delete();
        fb.push_back(8'h40);
        for (int i = 0; i < 259; i++) fb.push_back(8'($urandom));
        model(32);
        run_frame("long burst read", 1'b0);
        compare_frame("long burst read", 1'b0);

        // random frames against the reference model
        for (int f = 0; f < 40; f++) begin
            bit sel;
            int n;
            sel = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 6);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            model(sel ? 64 : 32);
            run_frame($sformatf("random frame %0d", f), sel);
            compare_frame($sformatf("random frame %0d", f), sel);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
